// File: rtl/serial_flag_alu_pkg.sv
// Shared encodings for the bit-serial flag ALU: operation codes and FSM states.
package serial_flag_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/serial_flag_alu_if.sv
// Request/result bundle between the execute-stage requester and the serial ALU.
// Handshake: start is sampled only while busy=0; done pulses one cycle when result/flags update.
interface serial_flag_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             sign;
  logic             overflow;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, zero, sign, overflow
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, zero, sign, overflow
  );
endinterface

// File: rtl/serial_flag_alu_slice.sv
// One-bit combinational ALU slice; SUB inverts b here so the carry chain is a plain adder.
module serial_alu_slice
  import serial_flag_alu_pkg::*;
(
  input  logic    a_i,
  input  logic    b_i,
  input  logic    cin_i,
  input  alu_op_e op_i,
  output logic    r_o,
  output logic    cout_o
);
  logic b_eff;

  always_comb begin
    b_eff  = (op_i == OP_SUB) ? ~b_i : b_i;
    r_o    = 1'b0;
    cout_o = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB: begin
        r_o    = a_i ^ b_eff ^ cin_i;
        cout_o = (a_i & b_eff) | (cin_i & (a_i ^ b_eff));
      end
      OP_AND:  r_o = a_i & b_i;
      OP_OR:   r_o = a_i | b_i;
      default: r_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/serial_flag_alu.sv
// Bit-serial ALU producing result + cout/zero/sign/overflow, LSB first.
// Define SERIAL_ALU_2BIT_EN to process two bits per cycle (WIDTH must be even).
module serial_flag_alu
  import serial_flag_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_flag_alu_if.slave bus,
  output alu_state_e       dbg_state_o
);
`ifdef SERIAL_ALU_2BIT_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH / STEP - 1);

  alu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d;
  alu_op_e          op_q, op_d;
  logic             carry_q, carry_d, zacc_q, zacc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d, zero_q, zero_d, sign_q, sign_d, ovf_q, ovf_d, done_q, done_d;

  logic             r0, c0;
  logic [STEP-1:0]  r_bits;
  logic             c_step, cin_msb, is_arith;

  serial_alu_slice u_slice0 (
    .a_i(a_sh_q[0]), .b_i(b_sh_q[0]), .cin_i(carry_q), .op_i(op_q), .r_o(r0), .cout_o(c0)
  );

`ifdef SERIAL_ALU_2BIT_EN
  logic r1, c1;
  if (WIDTH % 2 != 0) begin : g_width_chk
    $error("serial_flag_alu: WIDTH must be even when two bits are processed per cycle");
  end
  serial_alu_slice u_slice1 (
    .a_i(a_sh_q[1]), .b_i(b_sh_q[1]), .cin_i(c0), .op_i(op_q), .r_o(r1), .cout_o(c1)
  );
  assign r_bits  = {r1, r0};
  assign c_step  = c1;
  assign cin_msb = c0;
`else
  assign r_bits  = r0;
  assign c_step  = c0;
  assign cin_msb = carry_q;
`endif

  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    op_d     = op_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          op_d    = alu_op_e'(bus.op);
          cnt_d   = '0;
          carry_d = (alu_op_e'(bus.op) == OP_SUB);
          zacc_d  = 1'b0;
        end
      end
      ST_RUN: begin
        // Result bits enter at the MSB end so bit 0 lands at position 0 after the last step.
        a_sh_d   = a_sh_q >> STEP;
        b_sh_d   = b_sh_q >> STEP;
        res_sh_d = {r_bits, res_sh_q[WIDTH-1:STEP]};
        carry_d  = c_step;
        zacc_d   = zacc_q | (|r_bits);
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d  = ST_IDLE;
          result_d = res_sh_d;
          cout_d   = is_arith & c_step;
          ovf_d    = is_arith & (cin_msb ^ c_step);
          zero_d   = ~(zacc_q | (|r_bits));
          sign_d   = res_sh_d[WIDTH-1];
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      op_q     <= OP_ADD;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.zero     = zero_q;
  assign bus.sign     = sign_q;
  assign bus.overflow = ovf_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_serial_flag_alu.sv
// Scoreboard bench for serial_flag_alu: random and directed ops against an arithmetic model.
module tb_serial_flag_alu;
  import serial_flag_alu_pkg::*;

  localparam int W  = 32;
  localparam int EW = W + 4;
`ifdef SERIAL_ALU_2BIT_EN
  localparam int LAT = W / 2;
`else
  localparam int LAT = W;
`endif

  logic       clk;
  logic       rst_n;
  alu_state_e dbg_state;
  int         cycle_cnt;

  serial_flag_alu_if #(.WIDTH(W)) bus ();

  serial_flag_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .dbg_state_o(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int            iss_q[$];
  logic [EW-1:0] last_exp;
  logic [EW-1:0] act;
  logic [EW-1:0] popped;
  int            iss_cyc;
  int            checks = 0;
  int            errors = 0;
  int            issued = 0;
  int            done_seen = 0;

  task automatic check_val(input string name, input logic [EW-1:0] got, input logic [EW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // reference model: plain wide arithmetic, packed as {result, cout, zero, sign, overflow}
  function automatic logic [EW-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         co, ov;
    s = '0; r = '0; co = 1'b0; ov = 1'b0;
    case (op)
      2'b00: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'b01: begin
        s  = {1'b0, a} + {1'b0, ~b} + 1'b1;
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r, co, (r == '0), r[W-1], ov};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // monitor: pops an expectation on every done, otherwise outputs must hold while busy
  always @(negedge clk) begin
    if (rst_n) begin
      act = {bus.result, bus.cout, bus.zero, bus.sign, bus.overflow};
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required no done (t=%0t)", $time);
        end else begin
          popped  = exp_q.pop_front();
          iss_cyc = iss_q.pop_front();
          check_val("result_flags", act, popped);
          check_int("latency", cycle_cnt - iss_cyc, LAT);
          last_exp = popped;
          done_seen++;
        end
      end else if (bus.busy) begin
        check_val("hold_outputs", act, last_exp);
      end
    end
  end

  // driver tasks: called at a negedge with the DUT idle
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    exp_q.push_back(model(op, a, b));
    iss_q.push_back(cycle_cnt + 1);
    issued++;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    check_int("busy_after_start", int'(bus.busy), 1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check_int("wait_done_timeout", int'(seen), 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      if (!bus.busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_int("wait_idle_timeout", int'(ok), 1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(op, a, b);
    wait_idle();
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    last_exp  = '0;
    repeat (3) @(negedge clk);
    check_int("reset_busy", int'(bus.busy), 0);
    check_int("reset_done", int'(bus.done), 0);
    check_val("reset_outputs", {bus.result, bus.cout, bus.zero, bus.sign, bus.overflow}, '0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // directed corner cases
    run_op(2'b00, 32'h7FFF_FFFF, 32'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op(2'b01, 32'd5, 32'd5);
    run_op(2'b01, 32'd3, 32'd7);
    run_op(2'b10, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run_op(2'b11, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run_op(2'b01, 32'h8000_0000, 32'h0000_0001);

    // start while busy must be ignored
    issue(2'b00, 32'h1234_5678, 32'h1111_1111);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.a     = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (LAT + 8) @(negedge clk);

    // back-to-back: second start lands in the done cycle
    issue(2'b01, 32'h0000_0010, 32'h0000_0020);
    wait_done();
    issue(2'b00, 32'hAAAA_AAAA, 32'h5555_5555);
    wait_idle();

    // asynchronous reset mid-operation
    issue(2'b00, 32'h0F0F_0F0F, 32'h0101_0101);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_int("midreset_busy", int'(bus.busy), 0);
    check_int("midreset_done", int'(bus.done), 0);
    check_val("midreset_outputs", {bus.result, bus.cout, bus.zero, bus.sign, bus.overflow}, '0);
    exp_q.delete();
    iss_q.delete();
    last_exp = '0;
    issued   = done_seen;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_op(2'b00, 32'h7FFF_FFFF, 32'h0000_0001);

    // randomized traffic, sometimes chained in the done cycle
    for (int n = 0; n < 40; n++) begin
      issue(2'($urandom_range(0, 3)), rand_operand(), rand_operand());
      if ($urandom_range(0, 1) == 1) wait_done();
      else wait_idle();
    end
    wait_idle();
    repeat (4) @(negedge clk);

    check_int("done_count", done_seen, issued);
    check_int("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
